// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the button conditioning stage: the debounce FSM
// state encoding (also reused by the trigger-lab FSMs) and a helper that
// sizes the stability counter.
package btn_debounce_pulse_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        WAIT_HIGH = ST_WAIT_HIGH,
        HIGH      = ST_HIGH,
        WAIT_LOW  = ST_WAIT_LOW
    } state_e;

    // Counter width needed to count 0 .. n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// Two-flop synchroniser that brings one asynchronous button level into the
// C clock domain. One instance is used per button input.
module sync_2ff (
    input  logic C,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic s1_q;
    logic s2_q;

    // Shift the raw level through two flops; both clear on synchronous reset.
    always_ff @(posedge C) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

    assign dout = s2_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button conditioning stage: synchronises a bouncy raw level, accepts a new
// value only after it has held for STABLE_CYCLES clocks, and produces a clean
// level, one-cycle rise/fall pulses and a wrapping count of rise events.
module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int EVT_W         = 8
) (
    input  logic             C,
    input  logic             rst_n,
    input  logic             raw,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int             CNT_W    = cntWidth(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s2;
    logic             cntDone;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic [EVT_W-1:0] evtCnt_q;
    logic [EVT_W-1:0] evtCnt_d;

    sync_2ff u_sync (
        .C     (C),
        .rst_n (rst_n),
        .din   (raw),
        .dout  (s2)
    );

    assign cntDone = (cnt_q == CNT_LAST);

    // Register the FSM state together with the counter and all outputs.
    always_ff @(posedge C) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            evtCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            evtCnt_q <= evtCnt_d;
        end
    end

    // Next state: a new input value must survive a full wait window to be
    // accepted; any reversion during the window returns to the stable state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s2) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!s2)          state_d = IDLE;
                else if (cntDone) state_d = HIGH;
            end
            HIGH: begin
                if (!s2) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (s2)           state_d = HIGH;
                else if (cntDone) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and outputs: counter handling, clean level, single-cycle
    // pulses and the rise-event counter, which wraps freely.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        evtCnt_d = evtCnt_q;
        case (state_q)
            IDLE: begin
                if (s2) cnt_d = '0;
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    cnt_d = '0;
                end else if (cntDone) begin
                    level_d  = 1'b1;
                    rise_d   = 1'b1;
                    evtCnt_d = evtCnt_q + EVT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s2) cnt_d = '0;
            end
            WAIT_LOW: begin
                if (s2) begin
                    cnt_d = '0;
                end else if (cntDone) begin
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level   = level_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt_cnt = evtCnt_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse with STABLE_CYCLES=4 and a
// 2-bit event counter so the wrap is reachable quickly.
module tb_btn_debounce_pulse;

    localparam int STABLE = 4;
    localparam int EW     = 2;

    logic          C = 1'b0;
    logic          rst_n = 1'b0;
    logic          raw = 1'b0;
    logic          level;
    logic          rise;
    logic          fall;
    logic [EW-1:0] evt_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: raw is seen by the debouncer two edges late; the level
    // flips once the seen value has differed from it for STABLE+1 edges in a row.
    bit mH1, mH2, mLevel, mRise, mFall;
    int mRun, mEvt;

    typedef struct {
        bit rstN;
        bit raw;
        bit expLevel;
        bit expRise;
        bit expFall;
        int expEvt;
    } vec_t;

    vec_t vecs[$];

    always #5 C = ~C;

    btn_debounce_pulse #(
        .STABLE_CYCLES (STABLE),
        .EVT_W         (EW)
    ) dut (
        .C       (C),
        .rst_n   (rst_n),
        .raw     (raw),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .evt_cnt (evt_cnt)
    );

    task automatic checkValue(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelEdge(input bit r, input bit rstN);
        bit seen;
        if (!rstN) begin
            mH1 = 0; mH2 = 0; mLevel = 0; mRise = 0; mFall = 0; mRun = 0; mEvt = 0;
        end else begin
            seen  = mH2;
            mH2   = mH1;
            mH1   = r;
            mRise = 0;
            mFall = 0;
            if (seen != mLevel) begin
                mRun++;
                if (mRun == STABLE + 1) begin
                    mLevel = seen;
                    mRun   = 0;
                    if (seen) begin
                        mRise = 1;
                        mEvt  = (mEvt + 1) % (1 << EW);
                    end else begin
                        mFall = 1;
                    end
                end
            end else begin
                mRun = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit rstN);
        raw   = r;
        rst_n = rstN;
        @(posedge C);
        modelEdge(r, rstN);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".level"}, int'(level), int'(mLevel));
        checkValue({tag, ".rise"}, int'(rise), int'(mRise));
        checkValue({tag, ".fall"}, int'(fall), int'(mFall));
        checkValue({tag, ".evt_cnt"}, int'(evt_cnt), mEvt);
        checkValue({tag, ".riseFallExcl"}, int'(rise & fall), 0);
    endtask

    function automatic void addRows(input int n, input bit rstN, input bit r,
                                    input bit l, input bit ri, input bit f, input int e);
        for (int i = 0; i < n; i++) vecs.push_back('{rstN, r, l, ri, f, e});
    endfunction

    function automatic void addPress(input int evtOld, input int evtNew);
        addRows(6, 1, 1, 0, 0, 0, evtOld);
        addRows(1, 1, 1, 1, 1, 0, evtNew);
        addRows(1, 1, 1, 1, 0, 0, evtNew);
    endfunction

    function automatic void addRelease(input int evtNow);
        addRows(6, 1, 0, 1, 0, 0, evtNow);
        addRows(1, 1, 0, 0, 0, 1, evtNow);
        addRows(1, 1, 0, 0, 0, 0, evtNow);
    endfunction

    initial begin
        int riseCount;
        int fallCount;
        int highCount;
        int riseIdx;
        bit pat[$];

        // Reset with raw high, then the first press, release, and four more
        // presses so the 2-bit counter reads 1,2,3,0,1.
        addRows(3, 0, 1, 0, 0, 0, 0);
        addPress(0, 1);
        addRelease(1);
        for (int p = 2; p <= 5; p++) begin
            addPress((p - 1) % 4, p % 4);
            addRelease(p % 4);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].raw, vecs[i].rstN);
            checkValue($sformatf("vec%0d.level", i), int'(level), int'(vecs[i].expLevel));
            checkValue($sformatf("vec%0d.rise", i), int'(rise), int'(vecs[i].expRise));
            checkValue($sformatf("vec%0d.fall", i), int'(fall), int'(vecs[i].expFall));
            checkValue($sformatf("vec%0d.evt_cnt", i), int'(evt_cnt), vecs[i].expEvt);
        end

        // Bounce: 20 ns high/low toggles, then settle high; one rise pulse
        // six edges after the final 0->1.
        pat = '{1, 1, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 10; i++) pat.push_back(1'b1);
        riseCount = 0;
        riseIdx   = -1;
        for (int i = 0; i < pat.size(); i++) begin
            applyStimulus(pat[i], 1'b1);
            checkOutput($sformatf("bounce%0d", i));
            if (rise) begin
                riseCount++;
                riseIdx = i;
            end
        end
        checkValue("bounce.riseCount", riseCount, 1);
        checkValue("bounce.riseIdx", riseIdx, 14);
        checkValue("bounce.evt_cnt", int'(evt_cnt), 2);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("bounceRel%0d", i));
        end
        checkValue("bounceRel.level", int'(level), 0);
        checkValue("bounceRel.evt_cnt", int'(evt_cnt), 2);

        // Glitch: a 30 ns high pulse while idle leaves everything quiet.
        riseCount = 0;
        fallCount = 0;
        highCount = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(i < 3, 1'b1);
            checkOutput($sformatf("glitch%0d", i));
            riseCount += int'(rise);
            fallCount += int'(fall);
            highCount += int'(level);
        end
        checkValue("glitch.rises", riseCount, 0);
        checkValue("glitch.falls", fallCount, 0);
        checkValue("glitch.levelHigh", highCount, 0);

        // Reset in the middle of qualifying a press: raw stays high and is
        // re-qualified from scratch after release.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midReset");
        checkValue("midReset.evt_cnt", int'(evt_cnt), 0);
        riseIdx = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("midResetRel%0d", i));
            if (rise && riseIdx < 0) riseIdx = i;
        end
        checkValue("midReset.riseIdx", riseIdx, 6);
        checkValue("midReset.evtAfter", int'(evt_cnt), 1);

        // Random runs of raw with occasional resets, checked every cycle.
        for (int n = 0; n < 300; n++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(v, 1'b0);
                checkOutput($sformatf("rndRst%0d", n));
            end
            for (int k = 0; k < len; k++) begin
                applyStimulus(v, 1'b1);
                checkOutput($sformatf("rnd%0d_%0d", n, k));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
Upstream conditioning stage for the D flip-flop trigger experiments. It takes a raw, bouncy, asynchronous push-button or switch level and synchronises it into the clock domain. It then debounces the level and emits a clean level plus single-cycle rise and fall pulses, which drive the D inputs of the trigger circuits. A wrapping event counter lets the board display how many clean presses were seen.

Parameters:
STABLE_CYCLES, 4, consecutive clock cycles the synchronised input must hold a new value before it is accepted; legal range is 1 or more; use 4 in simulation and about 1_000_000 on the board.
EVT_W, 8, width of the rise-event counter.

Ports:
C  input  1  clock, rising-edge active
rst_n  input  1  synchronous active-low reset, sampled on rising edge of C
raw  input  1  asynchronous bouncy button level
level  output  1  debounced level
rise  output  1  one-cycle pulse when level goes 0->1
fall  output  1  one-cycle pulse when level goes 1->0
evt_cnt  output  EVT_W  count of rise pulses since reset, wraps

Behaviour:
- Clocking: one clock C. Reset is synchronous and active-low: every register takes its reset value on a rising edge of C with rst_n=0. There is no asynchronous reset path.
- Reset values: s1=0, s2=0, state=IDLE, cnt=0, level=0, rise=0, fall=0, evt_cnt=0.
- Synchroniser: s1<=raw; s2<=s1. The FSM uses only s2.
- cnt width: $clog2(STABLE_CYCLES) bits, with a minimum of 1.
- FSM states: IDLE (level 0), WAIT_HIGH, HIGH (level 1), WAIT_LOW.
  - IDLE: if s2=1, go to WAIT_HIGH with cnt<=0. Otherwise stay.
  - WAIT_HIGH: if s2=0, go to IDLE with cnt<=0 (bounce rejected, no pulse). If s2=1 and cnt=STABLE_CYCLES-1, go to HIGH with level<=1, rise<=1, evt_cnt<=evt_cnt+1. Otherwise cnt<=cnt+1.
  - HIGH: if s2=0, go to WAIT_LOW with cnt<=0.
  - WAIT_LOW: if s2=1, go to HIGH with cnt<=0 (no pulse). If s2=0 and cnt=STABLE_CYCLES-1, go to IDLE with level<=0, fall<=1. Otherwise cnt<=cnt+1.
- Pulses: rise and fall are registered and default to 0 every cycle. Each is high for exactly one cycle. They are never high together.
- Latency: raw changes before edge k and then stays stable. s2 reflects the change after edge k+1. The WAIT state is entered at edge k+2. level, rise or fall updates at edge k+2+STABLE_CYCLES. For STABLE_CYCLES=4 this is 6 edges.
- Glitch rejection: any input pulse shorter than STABLE_CYCLES cycles, as seen at s2, produces no level change.
- evt_cnt: wraps from 2^EVT_W-1 to 0 with no saturation. fall does not change it.
- Reset mid-operation: rst_n=0 in any state returns everything to reset values on that edge. A raw level that is still high afterwards is re-qualified from IDLE, so a fresh rise pulse appears after full latency.
- Unreachable state encodings go to IDLE.

Decomposition:
- Shared header (`include) holds the state encoding localparams ST_IDLE=2'd0, ST_WAIT_HIGH=2'd1, ST_HIGH=2'd2, ST_WAIT_LOW=2'd3. The trigger-lab FSMs reuse these.
- One sub-module, sync_2ff: 2-flop synchroniser with C/rst_n and 1-bit din/dout, reused for every button input.

Test Plan:
All scenarios use STABLE_CYCLES=4 and a 10 ns clock period.
- Reset: hold rst_n=0 for 3 edges with raw=1 -> level=0, rise=0, fall=0, evt_cnt=0. After release with raw still 1 -> rise pulses exactly 6 edges later and evt_cnt=1.
- Clean press: raw 0->1 before edge 10 and held -> level=1 and rise=1 after edge 16. rise=0 after edge 17. evt_cnt=1.
- Bounce: raw toggles 1,0,1,0 with a 20 ns high width, then settles at 1 -> exactly one rise pulse, 6 edges after the last 0->1. evt_cnt increments by 1.
- Glitch: a single 30 ns raw high pulse while idle -> level stays 0, with no rise and no fall pulses.
- Release: from HIGH, raw 1->0 held -> fall pulses for one cycle 6 edges later and level=0. evt_cnt unchanged.
- Wrap: EVT_W=2 with 5 clean presses -> evt_cnt reads 1,2,3,0,1.
